// File: rtl/alu.sv
// rtl/alu.sv - 32-bit single-cycle ALU with registered result and C/Z/N/V flags
module alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  op,
  input  logic [31:0] reg2,
  input  logic [31:0] reg3,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        zero_out,
  output logic        neg_out,
  output logic        over_out
);

  localparam logic [4:0] OP_ADD         = 5'h00;
  localparam logic [4:0] OP_ADDC        = 5'h01;
  localparam logic [4:0] OP_SUB         = 5'h02;
  localparam logic [4:0] OP_SUBC        = 5'h03;
  localparam logic [4:0] OP_AND         = 5'h04;
  localparam logic [4:0] OP_OR          = 5'h05;
  localparam logic [4:0] OP_XOR         = 5'h06;
  localparam logic [4:0] OP_COMP        = 5'h07;
  localparam logic [4:0] OP_BIT         = 5'h08;
  localparam logic [4:0] OP_MULU        = 5'h09;
  localparam logic [4:0] OP_MULS        = 5'h0A;
  localparam logic [4:0] OP_INC         = 5'h10;
  localparam logic [4:0] OP_DEC         = 5'h11;
  localparam logic [4:0] OP_NOT         = 5'h12;
  localparam logic [4:0] OP_LOGIC_LEFT  = 5'h13;
  localparam logic [4:0] OP_LOGIC_RIGHT = 5'h14;
  localparam logic [4:0] OP_ARITH_LEFT  = 5'h15;
  localparam logic [4:0] OP_ARITH_RIGHT = 5'h16;
  localparam logic [4:0] OP_NEG         = 5'h17;

  logic [31:0] result_d, result_q;
  logic        carry_d, carry_q;
  logic        zero_d, zero_q;
  logic        neg_d, neg_q;
  logic        over_d, over_q;

  logic        add_cin, sub_cin;
  logic [32:0] sum, diff;
  logic [31:0] mulu_p, muls_p;
  logic [31:0] flag_src;

  // carry_in only reaches the adder/subtractor for the explicit carry ops
  assign add_cin = (op == OP_ADDC) & carry_in;
  assign sub_cin = (op == OP_SUBC) & carry_in;
  assign sum     = {1'b0, reg2} + {1'b0, reg3} + {32'b0, add_cin};
  assign diff    = {1'b0, reg2} - {1'b0, reg3} - {32'b0, sub_cin};
  assign mulu_p  = {16'b0, reg2[15:0]} * {16'b0, reg3[15:0]};
  assign muls_p  = $signed({{16{reg2[15]}}, reg2[15:0]}) * $signed({{16{reg3[15]}}, reg3[15:0]});

  always_comb begin
    result_d = reg2;
    carry_d  = 1'b0;
    over_d   = 1'b0;
    flag_src = reg2;
    case (op)
      OP_ADD, OP_ADDC: begin
        result_d = sum[31:0];
        carry_d  = sum[32];
        over_d   = (reg2[31] == reg3[31]) && (sum[31] != reg2[31]);
        flag_src = sum[31:0];
      end
      OP_SUB, OP_SUBC: begin
        result_d = diff[31:0];
        carry_d  = diff[32];
        over_d   = (reg2[31] != reg3[31]) && (diff[31] != reg2[31]);
        flag_src = diff[31:0];
      end
      OP_COMP: begin
        carry_d  = diff[32];
        over_d   = (reg2[31] != reg3[31]) && (diff[31] != reg2[31]);
        flag_src = diff[31:0];
      end
      OP_AND: begin
        result_d = reg2 & reg3;
        flag_src = reg2 & reg3;
      end
      OP_OR: begin
        result_d = reg2 | reg3;
        flag_src = reg2 | reg3;
      end
      OP_XOR: begin
        result_d = reg2 ^ reg3;
        flag_src = reg2 ^ reg3;
      end
      OP_BIT: flag_src = reg2 & reg3;
      OP_MULU: begin
        result_d = mulu_p;
        flag_src = mulu_p;
      end
      OP_MULS: begin
        result_d = muls_p;
        flag_src = muls_p;
      end
      OP_INC: begin
        result_d = reg2 + 32'd1;
        carry_d  = (reg2 == 32'hFFFF_FFFF);
        flag_src = reg2 + 32'd1;
      end
      OP_DEC: begin
        result_d = reg2 - 32'd1;
        carry_d  = (reg2 == 32'd0);
        flag_src = reg2 - 32'd1;
      end
      OP_NOT: begin
        result_d = ~reg2;
        flag_src = ~reg2;
      end
      OP_LOGIC_LEFT, OP_ARITH_LEFT: begin
        result_d = {reg2[30:0], 1'b0};
        carry_d  = reg2[31];
        over_d   = (op == OP_ARITH_LEFT) && (reg2[31] ^ reg2[30]);
        flag_src = {reg2[30:0], 1'b0};
      end
      OP_LOGIC_RIGHT: begin
        result_d = {1'b0, reg2[31:1]};
        carry_d  = reg2[0];
        flag_src = {1'b0, reg2[31:1]};
      end
      OP_ARITH_RIGHT: begin
        result_d = {reg2[31], reg2[31:1]};
        carry_d  = reg2[0];
        flag_src = {reg2[31], reg2[31:1]};
      end
      OP_NEG: begin
        result_d = 32'd0 - reg2;
        carry_d  = (reg2 != 32'd0);
        over_d   = (reg2 == 32'h8000_0000);
        flag_src = 32'd0 - reg2;
      end
      default: ;
    endcase
    zero_d = (flag_src == 32'd0);
    neg_d  = flag_src[31];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= 32'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      over_q   <= over_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero_out  = zero_q;
  assign neg_out   = neg_q;
  assign over_out  = over_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - vector table, reset sequences and randomized model check for alu
module tb_alu;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  op;
  logic [31:0] reg2, reg3;
  logic        carry_in;
  logic [31:0] result;
  logic        carry_out, zero_out, neg_out, over_out;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu dut (
    .clock(clock), .reset(reset), .op(op), .reg2(reg2), .reg3(reg3),
    .carry_in(carry_in), .result(result), .carry_out(carry_out),
    .zero_out(zero_out), .neg_out(neg_out), .over_out(over_out)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [35:0] exp;   // {result, C, Z, N, V}
  } vec_t;

  function automatic logic [35:0] model(input logic [4:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    longint unsigned ua, ub, s, t;
    longint          sa, sb;
    logic [63:0]     p;
    logic [31:0]     r, fs;
    logic            c, v, use_r;
    ua = a; ub = b;
    r = a; c = 0; v = 0; use_r = 1; fs = a;
    case (o)
      5'h00, 5'h01: begin
        s = ua + ub + ((o == 5'h01) ? cin : 0);
        r = s[31:0]; c = (s >= 64'h1_0000_0000);
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'h02, 5'h03, 5'h07: begin
        t = ub + ((o == 5'h03) ? cin : 0);
        r = 32'(ua - t); c = (ua < t);
        v = (a[31] != b[31]) && (r[31] != a[31]);
        if (o == 5'h07) begin fs = r; r = a; use_r = 0; end
      end
      5'h04: r = a & b;
      5'h05: r = a | b;
      5'h06: r = a ^ b;
      5'h08: begin fs = a & b; use_r = 0; end
      5'h09: r = 32'((ua % 65536) * (ub % 65536));
      5'h0A: begin
        sa = longint'(ua % 65536); if (sa > 32767) sa = sa - 65536;
        sb = longint'(ub % 65536); if (sb > 32767) sb = sb - 65536;
        p = 64'(sa * sb); r = p[31:0];
      end
      5'h10: begin r = 32'(ua + 1); c = (ua + 1 == 64'h1_0000_0000); end
      5'h11: begin r = 32'(ua - 1); c = (ua == 0); end
      5'h12: r = ~a;
      5'h13, 5'h15: begin
        r = 32'(ua * 2); c = (ua >= 64'h8000_0000);
        if (o == 5'h15) v = (a[31] != a[30]);
      end
      5'h14: begin r = 32'(ua / 2); c = (ua % 2 == 1); end
      5'h16: begin sa = longint'($signed(a)); r = 32'(sa >>> 1); c = (ua % 2 == 1); end
      5'h17: begin r = 32'(64'h1_0000_0000 - ua); c = (ua != 0); v = (ua == 64'h8000_0000); end
      default: r = a;
    endcase
    if (use_r) fs = r;
    return {r, c, (fs == 0), fs[31], v};
  endfunction

  task automatic check(input string name, input logic [35:0] exp);
    logic [35:0] got;
    got = {result, carry_out, zero_out, neg_out, over_out};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got res=%h CZNV=%b expected res=%h CZNV=%b",
               name, got[35:4], got[3:0], exp[35:4], exp[3:0]);
    end
  endtask

  task automatic apply(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    op = o; reg2 = a; reg3 = b; carry_in = cin;
    @(posedge clock); #1;
  endtask

  vec_t vecs[$];
  logic [31:0] corner[8];

  initial begin
    vecs.push_back('{5'h00, 32'h4000_0000, 32'h4000_0000, 1'b0, {32'h8000_0000, 4'b0011}});
    vecs.push_back('{5'h01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {32'h0000_0000, 4'b1100}});
    vecs.push_back('{5'h03, 32'h0000_0000, 32'h8000_0000, 1'b0, {32'h8000_0000, 4'b1011}});
    vecs.push_back('{5'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFF, 4'b1010}});
    vecs.push_back('{5'h07, 32'h0000_0001, 32'h0000_0002, 1'b0, {32'h0000_0001, 4'b1010}});
    vecs.push_back('{5'h08, 32'h0808_0808, 32'h8080_8080, 1'b0, {32'h0808_0808, 4'b0100}});
    vecs.push_back('{5'h0A, 32'h0000_7FFF, 32'h0000_8000, 1'b0, {32'hC000_8000, 4'b0010}});
    vecs.push_back('{5'h09, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, {32'hFFFE_0001, 4'b0010}});
    vecs.push_back('{5'h15, 32'h8080_8080, 32'h0, 1'b0, {32'h0101_0100, 4'b1001}});
    vecs.push_back('{5'h16, 32'h8080_8080, 32'h0, 1'b0, {32'hC040_4040, 4'b0010}});
    vecs.push_back('{5'h10, 32'h7FFF_FFFF, 32'h0, 1'b0, {32'h8000_0000, 4'b0010}});
    vecs.push_back('{5'h11, 32'h0000_0000, 32'h0, 1'b1, {32'hFFFF_FFFF, 4'b1010}});
    vecs.push_back('{5'h17, 32'h8000_0000, 32'h0, 1'b0, {32'h8000_0000, 4'b1011}});
    vecs.push_back('{5'h17, 32'h0000_0000, 32'h0, 1'b0, {32'h0000_0000, 4'b0100}});
    vecs.push_back('{5'h1F, 32'h0000_0000, 32'h1234_5678, 1'b1, {32'h0000_0000, 4'b0100}});
    vecs.push_back('{5'h14, 32'h0000_0001, 32'h0, 1'b0, {32'h0000_0000, 4'b1100}});
    vecs.push_back('{5'h13, 32'h8000_0000, 32'h0, 1'b0, {32'h0000_0000, 4'b1100}});

    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
               32'h0000_FFFF, 32'h0000_8000, 32'h4000_0000};

    reset = 1'b1; op = 5'h00; reg2 = 32'h1; reg3 = 32'h1; carry_in = 1'b0;
    @(posedge clock); #1;
    check("reset_state", 36'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d_op%02h", i, vecs[i].op), vecs[i].exp);
    end

    // reset mid-stream with ADD presented, then release and see ADD result
    apply(5'h00, 32'h0000_0005, 32'h0000_0007, 1'b0);
    check("add_before_reset", {32'h0000_000C, 4'b0000});
    reset = 1'b1;
    @(posedge clock); #1;
    check("reset_mid_stream", 36'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("add_after_reset", {32'h0000_000C, 4'b0000});

    // back-to-back ops: each edge reflects only the op presented just before it
    apply(5'h12, 32'h0000_0000, 32'h0, 1'b1);
    check("b2b_not", {32'hFFFF_FFFF, 4'b0010});
    apply(5'h05, 32'h0, 32'h0, 1'b1);
    check("b2b_or_zero", {32'h0, 4'b0100});

    for (int i = 0; i < 400; i++) begin
      logic [4:0]  o;
      logic [31:0] a, b;
      logic        ci;
      o  = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
      ci = 1'($urandom_range(0, 1));
      apply(o, a, b, ci);
      check($sformatf("rand%0d_op%02h_a%h_b%h_c%0d", i, o, a, b, ci), model(o, a, b, ci));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits, op width fixed at 5 bits.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  5  operation select (encodings REQ-008).
REQ-005 reg2, reg3  input  32 each  first and second operand.
REQ-006 carry_in  input  1  carry/borrow in; used only by ADDC/SUBC.
REQ-007 result  output  32; carry_out, zero_out, neg_out, over_out  output  1 each; all registered.

Function
REQ-008 SHALL decode op as: ADD=00, ADDC=01, SUB=02, SUBC=03, AND=04, OR=05, XOR=06, COMP=07, BIT=08, MULU=09, MULS=0A, INC=10, DEC=11, NOT=12, LOGIC_LEFT=13, LOGIC_RIGHT=14, ARITH_LEFT=15, ARITH_RIGHT=16, NEG=17, TEST=18 (hex).
REQ-009 SHALL compute next result/flags combinationally from the current inputs and load them into the output registers on every rising clock edge; latency exactly 1 cycle; new operation accepted every cycle.
REQ-010 Unless stated otherwise: zero = (flag-source value == 0), neg = bit 31 of flag-source value, carry = 0, over = 0; flag source = result.
REQ-011 ADD/ADDC: {carry,result} = reg2 + reg3 (+ carry_in for ADDC), 33-bit sum; over = (reg2[31]==reg3[31]) and (result[31]!=reg2[31]).
REQ-012 SUB/SUBC: result = reg2 - reg3 (- carry_in for SUBC); carry = borrow (bit 32 of 33-bit zero-extended difference); over = (reg2[31]!=reg3[31]) and (result[31]!=reg2[31]).
REQ-013 AND/OR/XOR/NOT: bitwise reg2 op reg3 (NOT: ~reg2).
REQ-014 COMP: result = reg2 unchanged; carry/zero/neg/over as SUB of reg2 - reg3.
REQ-015 BIT: result = reg2 unchanged; zero/neg from (reg2 & reg3); carry = over = 0.
REQ-016 MULU: result = reg2[15:0] * reg3[15:0] unsigned, 32-bit product.
REQ-017 MULS: result = signed(reg2[15:0]) * signed(reg3[15:0]), 32-bit two's-complement product.
REQ-018 INC: {carry,result} = reg2 + 1; over = 0.
REQ-019 DEC: result = reg2 - 1; carry = borrow (1 only when reg2 == 0); over = 0.
REQ-020 LOGIC_LEFT: result = reg2 << 1, bit0 = 0; carry = reg2[31].
REQ-021 LOGIC_RIGHT: result = reg2 >> 1, bit31 = 0; carry = reg2[0].
REQ-022 ARITH_LEFT: as LOGIC_LEFT; over = reg2[31] xor reg2[30].
REQ-023 ARITH_RIGHT: result = {reg2[31], reg2[31:1]}; carry = reg2[0].
REQ-024 NEG: result = 0 - reg2; carry = (reg2 != 0); over = (reg2 == 32'h80000000).
REQ-025 TEST: result = reg2; flags per REQ-010.
REQ-026 carry_in SHALL be ignored by all ops other than ADDC/SUBC; reg3 ignored by ops 10-18.
REQ-027 Undefined op codes SHALL behave as TEST.
REQ-028 All arithmetic wraps modulo 2^32; no saturation.

Reset
REQ-029 While reset is high at a rising edge, result SHALL load 0 and all four flags SHALL load 0 (zero_out = 0 despite result = 0); reset overrides any op in that cycle.
REQ-030 First valid result SHALL appear one edge after reset deasserts and the op is presented.

Verification
REQ-031 ADD 40000000+40000000 -> result 80000000, C0 Z0 N1 V1; ADDC ffffffff+0, cin=1 -> 00000000, C1 Z1 N0 V0.
REQ-032 SUBC 00000000-80000000, cin=0 -> 80000000, C1 Z0 N1 V1; SUBC ffffffff-ffffffff, cin=1 -> ffffffff, C1 N1.
REQ-033 COMP 1 vs 2 -> result 00000001, C1 Z0 N1 V0; BIT 08080808 & 80808080 -> result 08080808, Z1.
REQ-034 MULS 7fff*8000 -> c0008000 N1; MULU ffff*ffff -> fffe0001 N1.
REQ-035 ARITH_LEFT 80808080 -> 01010100, C1 V1; ARITH_RIGHT 80808080 -> c0404040 N1; INC 7fffffff -> 80000000 N1 V0.
REQ-036 Reset asserted mid-stream with ADD active -> next edge all outputs 0; releases -> following edge shows ADD result.
